heartbeat_monitor: RTL
======================

// Module: heartbeat_monitor
// PURPOSE
//  Receive-side checker for the FPGA debug LED heartbeats: each count_clk instance
//  divides a clock into a toggling LED signal; this block watches one such toggle.
//  It synchronises the asynchronous toggle into its own reference clock domain and
//  measures the half-period (toggle to toggle) in reference cycles.
//  It reports lock, too-fast and too-slow/stalled conditions.
//  Instantiated in the Xilinx top, one per heartbeat, clocked from the board reference clock.
// PARAMETERS
//  SYNC_STAGES  2            synchroniser depth for hb_i (>=2)
//  CNT_W        32           width of cycle counter and period_o
//  MIN_HALF     40000000     smallest legal half-period, in clk cycles
//  MAX_HALF     60000000     largest legal half-period, in clk cycles (MIN_HALF<MAX_HALF<2**CNT_W-1)
//  LOCK_N       4            consecutive in-range half-periods required to assert locked_o
// PORTS
//  clk             in   1      reference clock
//  reset_n         in   1      asynchronous active-low reset
//  enable_i        in   1      1 = monitor runs; 0 = return to IDLE
//  clear_i         in   1      1-cycle pulse: clears sticky errors and edge_cnt_o
//  hb_i            in   1      heartbeat toggle, asynchronous to clk
//  period_o        out  CNT_W  last measured half-period, in clk cycles
//  period_valid_o  out  1      1-cycle pulse when period_o updates
//  locked_o        out  1      LOCK_N consecutive in-range measurements seen
//  err_fast_o      out  1      sticky: a half-period < MIN_HALF was measured
//  err_slow_o      out  1      sticky: no edge within MAX_HALF cycles (stall or too slow)
//  edge_cnt_o      out  16     edges detected while enabled; wraps at 0xFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, synchroniser flops 0, cnt=0, good_cnt=0.
//  Sync: hb_i passes through SYNC_STAGES flops plus one history flop. edge = sync_out XOR hist.
//   Both rising and falling edges count. edge is seen SYNC_STAGES+1 cycles after hb_i changes.
//  FSM:
//   IDLE: cnt=0. Move to ARM when enable_i=1; the history flop is loaded from sync_out, so no false edge.
//   ARM: wait for the first edge; cnt counts.
//     edge -> MEAS, cnt<=0, no period reported.
//     cnt+1 == MAX_HALF without an edge -> err_slow_o<=1, cnt<=0, stay ARM.
//   MEAS: cnt increments every cycle; cnt<=0 on edge. On edge: meas=cnt+1.
//     Edges k cycles apart give meas=k.
//     period_o<=meas, period_valid_o=1 in the next cycle.
//     meas<MIN_HALF -> err_fast_o<=1, good_cnt<=0, locked_o<=0.
//     else good_cnt<=sat(good_cnt+1). locked_o<=1 once good_cnt reaches LOCK_N.
//     No edge and cnt+1==MAX_HALF -> err_slow_o<=1, locked_o<=0, good_cnt<=0, ->ARM, cnt<=0.
//     meas==MAX_HALF is legal; the timeout fires one cycle later.
//  enable_i=0 in any state: next cycle ->IDLE; locked_o<=0, good_cnt<=0.
//   period_o, sticky errors and edge_cnt_o hold their values.
//  clear_i: err_fast_o, err_slow_o, edge_cnt_o <= 0. If it coincides with a new error or edge
//   in the same cycle, the new event wins (flag set / count = 1).
//  edge_cnt_o increments on every detected edge in ARM or MEAS.
//  Counter: cnt is CNT_W bits and never exceeds MAX_HALF-1, so it never wraps.
//  reset_n asserted mid-measurement: immediate return to reset values; no partial period_o.
// TESTING (MIN_HALF=8, MAX_HALF=16, LOCK_N=3, SYNC_STAGES=2)
//  1 hb_i toggles every 10 cycles -> period_o=10 with period_valid_o on each edge after the first.
//    locked_o=1 after the 3rd measurement; no errors.
//  2 Lock, then hb_i held constant -> err_slow_o=1 and locked_o=0 exactly 16 cycles after the last edge.
//    Then 10-cycle toggling resumes -> relock after 3 measurements; err_slow_o stays 1 until clear_i.
//  3 Toggle every 5 cycles -> err_fast_o=1 at the first measurement, period_o=5, locked_o stays 0.
//  4 Boundaries: toggle every 8 then every 16 cycles -> both legal, no errors.
//    Toggle every 17 cycles -> err_slow_o, FSM back in ARM.
//  5 Lock, drop enable_i for 1 cycle, then re-enable with hb_i static high -> locked_o=0, no spurious edge.
//    edge_cnt_o is unchanged until the next real toggle.
//  6 Assert reset_n low mid-count, with asynchronous jitter on hb_i -> all outputs 0 immediately.
//    After release, the first period_valid_o follows two real edges.

Source files
------------

// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: synchronises an async LED toggle and measures its half-period, lock and faults.
// Latency: edge acted on SYNC_STAGES+1 cycles after hb_i moves, period_o one cycle later; no backpressure.
module heartbeat_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MIN_HALF    = 40000000,
  parameter int unsigned MAX_HALF    = 60000000,
  parameter int unsigned LOCK_N      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             hb_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             err_fast_o,
  output logic             err_slow_o,
  output logic [15:0]      edge_cnt_o
);

  localparam int unsigned      GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] TMO_V  = CNT_W'(MAX_HALF - 1);
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [GOOD_W-1:0]      good_q;

  logic                   sync_out;
  logic                   hb_edge;
  logic                   counted_edge;
  logic                   timeout;
  logic [CNT_W-1:0]       meas;
  logic [GOOD_W-1:0]      good_inc;

  assign sync_out     = sync_q[SYNC_STAGES-1];
  // History always tracks sync_out, so entering ARM from IDLE never sees a stale edge.
  assign hb_edge      = sync_out ^ hist_q;
  assign counted_edge = hb_edge && enable_i && (state_q != S_IDLE);
  assign timeout      = (cnt_q == TMO_V);
  assign meas         = cnt_q + CNT_W'(1);
  assign good_inc     = (good_q == LOCK_V) ? good_q : good_q + GOOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hb_i};
      hist_q <= sync_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      good_q         <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      err_fast_o     <= 1'b0;
      err_slow_o     <= 1'b0;
      edge_cnt_o     <= '0;
    end else begin
      period_valid_o <= 1'b0;

      // Clear first; any event in the same cycle overrides it below.
      if (clear_i) begin
        err_fast_o <= 1'b0;
        err_slow_o <= 1'b0;
        edge_cnt_o <= '0;
      end
      if (counted_edge) edge_cnt_o <= clear_i ? 16'd1 : edge_cnt_o + 16'd1;

      if (!enable_i) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        good_q   <= '0;
        locked_o <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_q   <= '0;
            state_q <= S_ARM;
          end
          S_ARM: begin
            if (hb_edge) begin
              state_q <= S_MEAS;
              cnt_q   <= '0;
            end else if (timeout) begin
              err_slow_o <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_MEAS: begin
            if (hb_edge) begin
              cnt_q          <= '0;
              period_o       <= meas;
              period_valid_o <= 1'b1;
              if (meas < MIN_V) begin
                err_fast_o <= 1'b1;
                good_q     <= '0;
                locked_o   <= 1'b0;
              end else begin
                good_q   <= good_inc;
                locked_o <= (good_inc == LOCK_V);
              end
            end else if (timeout) begin
              err_slow_o <= 1'b1;
              locked_o   <= 1'b0;
              good_q     <= '0;
              cnt_q      <= '0;
              state_q    <= S_ARM;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
